// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// Optional BCD_INVALID_CHECK_EN adds a sticky err output flagging non-BCD digits.
module bcd_serial_adder #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  sub,
    input  logic                  cin,
    input  logic [4*DIGITS-1:0]   a,
    input  logic [4*DIGITS-1:0]   b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   sum,
    output logic                  cout
`ifdef BCD_INVALID_CHECK_EN
    ,
    output logic                  err
`endif
);

    localparam int W  = 4 * DIGITS;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic          sub_q, sub_d, carry_q, carry_d, cout_q, cout_d;

    logic [3:0]    a_dig, b_dig, bd, dig;
    logic [4:0]    raw, raw_adj;
    logic          dig_carry, last_dig;

`ifdef BCD_INVALID_CHECK_EN
    logic          err_q, err_d;
`endif

    // Single digit-adder slice; subtraction uses nine's complement plus initial carry.
    always_comb begin
        a_dig     = a_q[4*idx_q +: 4];
        b_dig     = b_q[4*idx_q +: 4];
        bd        = sub_q ? (4'd9 - b_dig) : b_dig;
        raw       = {1'b0, a_dig} + {1'b0, bd} + {4'b0000, carry_q};
        raw_adj   = raw + 5'd6;
        dig_carry = (raw > 5'd9);
        dig       = dig_carry ? raw_adj[3:0] : raw[3:0];
        last_dig  = (idx_q == IW'(DIGITS - 1));
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef BCD_INVALID_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) state_d = IDLE;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sub_d   = sub;
                    carry_d = sub | cin;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef BCD_INVALID_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            RUN: begin
                sum_d[4*idx_q +: 4] = dig;
                carry_d = dig_carry;
`ifdef BCD_INVALID_CHECK_EN
                if (a_dig > 4'd9 || b_dig > 4'd9) err_d = 1'b1;
`endif
                if (last_dig) begin
                    cout_d  = dig_carry;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef BCD_INVALID_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef BCD_INVALID_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef BCD_INVALID_CHECK_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Scoreboard bench for bcd_serial_adder (DIGITS=4); covers err when BCD_INVALID_CHECK_EN is defined.
module tb_bcd_serial_adder;

    localparam int D = 4;

    typedef struct {
        logic [4*D-1:0] sum;
        logic           cout;
        logic           err;
        bit             chk_sum;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst, start, sub, cin;
    logic [4*D-1:0] a, b, sum;
    logic           busy, done, cout;
`ifdef BCD_INVALID_CHECK_EN
    logic           err;
`endif

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic [4*D-1:0] last_sum;
    logic           last_cout;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .sub  (sub),
        .cin  (cin),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .sum  (sum),
        .cout (cout)
`ifdef BCD_INVALID_CHECK_EN
        ,
        .err  (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic int bcd2int(input logic [4*D-1:0] v);
        int r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [4*D-1:0] int2bcd(input int v);
        logic [4*D-1:0] r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [4*D-1:0] rand_bcd();
        logic [4*D-1:0] r;
        for (int i = 0; i < D; i++) r[4*i +: 4] = 4'($urandom_range(9, 0));
        return r;
    endfunction

    // Drive a request at the current negedge; optionally push its expected result.
    task automatic launch(input logic [4*D-1:0] ai, input logic [4*D-1:0] bi,
                          input logic si, input logic ci, input bit push);
        exp_t e;
        int   p = 1, x, y, r;
        bit   bad = 0;
        for (int i = 0; i < D; i++) begin
            p = p * 10;
            if (ai[4*i +: 4] > 4'd9 || bi[4*i +: 4] > 4'd9) bad = 1;
        end
        x = bcd2int(ai);
        y = bcd2int(bi);
        if (si) begin
            r      = x - y + p;
            e.cout = (x >= y);
        end else begin
            r      = x + y + int'(ci);
            e.cout = (r >= p);
        end
        e.sum     = int2bcd(r % p);
        e.err     = bad;
        e.chk_sum = !bad;
        if (push) sb.push_back(e);
        a = ai; b = bi; sub = si; cin = ci; start = 1'b1;
    endtask

    // Wait for done after a launch; inj>0 pulses a stray start at that RUN cycle.
    task automatic finish_op(input int inj);
        int   cyc, bc;
        exp_t e;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        bc  = 0;
        while (!done && cyc < 20) begin
            if (busy) bc++;
            if (cyc == inj) begin
                start = 1'b1; a = 16'h1111; b = 16'h2222; sub = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("latency", 64'(cyc), 64'd5);
        check("busy_len", 64'(bc), 64'd4);
        if (sb.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            check("busy_in_done", {63'd0, busy}, 64'd0);
            if (e.chk_sum) check("sum", 64'(sum), 64'(e.sum));
            if (e.chk_sum) check("cout", {63'd0, cout}, {63'd0, e.cout});
`ifdef BCD_INVALID_CHECK_EN
            check("err", {63'd0, err}, {63'd0, e.err});
`endif
            last_sum  = sum;
            last_cout = cout;
        end
    endtask

    task automatic check_hold();
        @(negedge clk);
        check("done_pulse", {63'd0, done}, 64'd0);
        check("hold_sum", 64'(sum), 64'(last_sum));
        check("hold_cout", {63'd0, last_cout}, {63'd0, cout});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", {63'd0, cout}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        launch(16'h1234, 16'h5678, 1'b0, 1'b0, 1); finish_op(0); check("add_6912", 64'(sum), 64'h6912); check_hold();
        launch(16'h9999, 16'h0001, 1'b0, 1'b0, 1); finish_op(0); check_hold();
        launch(16'h0000, 16'h0000, 1'b0, 1'b1, 1); finish_op(0); check_hold();
        launch(16'h5000, 16'h1234, 1'b1, 1'b0, 1); finish_op(0); check("sub_3766", 64'(sum), 64'h3766); check_hold();
        launch(16'h0000, 16'h0001, 1'b1, 1'b0, 1); finish_op(0); check("neg_9999", 64'(sum), 64'h9999); check_hold();
        launch(16'h0042, 16'h0042, 1'b1, 1'b1, 1); finish_op(0); check_hold();

        // Stray start mid-RUN, then back-to-back start in the DONE cycle.
        launch(16'h1234, 16'h5678, 1'b0, 1'b0, 1); finish_op(2);
        check("ignored_start", 64'(sum), 64'h6912);
        check("done_seen", {63'd0, done}, 64'd1);
        launch(16'h0321, 16'h0789, 1'b0, 1'b0, 1); finish_op(0); check_hold();

        // Reset in the middle of RUN discards the operation.
        launch(16'h4321, 16'h1111, 1'b0, 1'b0, 0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_done", {63'd0, done}, 64'd0);
        check("mid_rst_sum", 64'(sum), 64'd0);
        check("mid_rst_cout", {63'd0, cout}, 64'd0);
        launch(16'h0005, 16'h0005, 1'b0, 1'b0, 1); finish_op(0); check("add_0010", 64'(sum), 64'h0010); check_hold();

`ifdef BCD_INVALID_CHECK_EN
        launch(16'h12A4, 16'h0001, 1'b0, 1'b0, 1); finish_op(0); check_hold();
        check("err_sticky", {63'd0, err}, 64'd1);
        launch(16'h0001, 16'h0001, 1'b0, 1'b0, 1); finish_op(0); check("after_err", 64'(sum), 64'h0002);
`endif

        for (int n = 0; n < 20; n++) begin
            launch(rand_bcd(), rand_bcd(), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1);
            finish_op(0);
        end

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
